uart_rx_param: RTL

- Parametrised UART receiver; next generation of the existing RX top.
- Adds generic data width, runtime 1/2 stop bits and 3-sample majority voting.
- Adds an input synchroniser, a valid/ready output handshake with overrun detection, and frame config latched at the start of each frame.
- Sits behind the RX pin; feeds the register-file/control FSM in the RX clock domain.

---
 rtl/uart_rx_param.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-flop input synchroniser,
// 3-sample majority voting, optional parity, 1/2 stop bits and a valid/ready
// holding register with overrun detection. Frame config is latched at the
// start edge.
// Optional feature macro: UART_RX_BREAK_DET_EN (break detection, BREAK_WAIT).
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | line idle, waiting for rx_s = 0 with a legal prescale
// S_START      | sampling start bit; voted 1 aborts as a glitch
// S_DATA       | shifting DATA_WIDTH data bits, LSB first
// S_PARITY     | sampling parity bit, mismatch held until frame end
// S_STOP       | sampling 1 or 2 stop bits, frame end on the last one
// S_BREAK_WAIT | break seen, waiting for the line to return high
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STP2,
    input  logic                  RX_IN,
    input  logic                  Data_ready,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_valid,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  OVR_ERR,
    output logic                  BUSY,
    output logic                  BRK_DET
);

    localparam int BC_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_RX_BREAK_DET_EN
        , S_BREAK_WAIT
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic                    rx_meta_q, rx_s_q;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    stp2_q, stp2_d;
    logic [PRESCALE_W-1:0]   edge_q, edge_d;
    logic [BC_W-1:0]         bit_q, bit_d;
    logic [2:0]              smp_q, smp_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_bad_q, par_bad_d;
    logic                    stp_bad_q, stp_bad_d;
    logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
    logic                    valid_q, valid_d;
    logic                    par_err_q, par_err_d;
    logic                    stp_err_q, stp_err_d;
    logic                    ovr_q, ovr_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                    brk_q, brk_d;
    logic                    zero_q, zero_d;
`endif

    logic [PRESCALE_W-1:0]   half;
    logic                    last_edge;
    logic                    voted;
    logic                    presc_ok;
    logic                    stop_bad_now;

    assign half      = presc_q >> 1;
    assign last_edge = (edge_q == presc_q - PRESCALE_W'(1));
    assign voted     = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign presc_ok  = (Prescale == PRESCALE_W'(8)) || (Prescale == PRESCALE_W'(16)) ||
                       (Prescale == PRESCALE_W'(32));
    assign stop_bad_now = stp_bad_q | ~voted;

    // Two-flop synchroniser on the asynchronous serial line, idles high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters, latched frame config and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stp2_q    <= 1'b0;
            edge_q    <= '0;
            bit_q     <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            stp_bad_q <= 1'b0;
            pdata_q   <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q     <= 1'b0;
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stp2_q    <= stp2_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            smp_q     <= smp_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            stp_bad_q <= stp_bad_d;
            pdata_q   <= pdata_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_BREAK_DET_EN
            brk_q     <= brk_d;
            zero_q    <= zero_d;
`endif
        end
    end

    // Next-state logic: bit timing, voting, frame-end delivery and handshake.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stp2_d    = stp2_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        smp_d     = smp_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        stp_bad_d = stp_bad_q;
        pdata_d   = pdata_q;
        valid_d   = valid_q & ~Data_ready;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
        ovr_d     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_d     = 1'b0;
        zero_d    = zero_q;
`endif

        if (state_q != S_IDLE) begin
            edge_d = last_edge ? '0 : edge_q + PRESCALE_W'(1);
            if (edge_q == half - PRESCALE_W'(1)) smp_d[0] = rx_s_q;
            if (edge_q == half)                  smp_d[1] = rx_s_q;
            if (edge_q == half + PRESCALE_W'(1)) smp_d[2] = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q && presc_ok) begin
                    state_d   = S_START;
                    edge_d    = '0;
                    bit_d     = '0;
                    presc_d   = Prescale;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stp2_d    = STP2;
                    par_bad_d = 1'b0;
                    stp_bad_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d    = 1'b1;
`endif
                end
            end
            S_START: begin
                if (edge_q == half + PRESCALE_W'(2) && voted) begin
                    state_d = S_IDLE;
                end else if (last_edge) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (last_edge) begin
                    shift_d = {voted, shift_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                    zero_d  = zero_q & ~voted;
`endif
                    if (bit_q == BC_W'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (last_edge) begin
                    if (voted != (^shift_q ^ par_typ_q)) par_bad_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d  = zero_q & ~voted;
`endif
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (last_edge) begin
`ifdef UART_RX_BREAK_DET_EN
                    if (bit_q == '0 && zero_q && !voted) begin
                        brk_d   = 1'b1;
                        state_d = S_BREAK_WAIT;
                    end else
`endif
                    if (bit_q == {{(BC_W-1){1'b0}}, stp2_q}) begin
                        state_d = S_IDLE;
                        if (par_bad_q || stop_bad_now) begin
                            par_err_d = par_bad_q;
                            stp_err_d = stop_bad_now;
                        end else if (!valid_q || Data_ready) begin
                            pdata_d = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        bit_d     = bit_q + BC_W'(1);
                        stp_bad_d = stop_bad_now;
                    end
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            S_BREAK_WAIT: begin
                if (rx_s_q) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign P_DATA     = pdata_q;
    assign Data_valid = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign OVR_ERR    = ovr_q;
    assign BUSY       = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
    assign BRK_DET    = brk_q;
`else
    assign BRK_DET    = 1'b0;
`endif

endmodule
